fruit_ctrl: RTL

FRUIT_CTRL -- requirements
Module: fruit_ctrl

---
 rtl/fruit_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fruit_ctrl.sv
// Fruit-slicing game controller: launch/flight/cut/miss sequencing, lives and cut count.
// Optional macro FRUIT_CTRL_TIMEOUT_EN: a fruit left in flight FLIGHT_TIMEOUT frames counts as a miss.
module fruit_ctrl #(
  parameter int LIVES          = 3,
  parameter int GRACE_FRAMES   = 8,
  parameter int CUT_HOLD       = 4,
  parameter int Y_MAX          = 479,
  parameter int FLIGHT_TIMEOUT = 255
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [9:0] fruitX,
  input  logic [9:0] fruitY,
  input  logic [9:0] fruitS,
  input  logic [9:0] bladeX,
  input  logic [9:0] bladeY,
  input  logic       blade_valid,
  output logic       new_fruit,
  output logic       move_fruit,
  output logic [7:0] number_of_fruits_cut,
  output logic [2:0] lives,
  output logic       cut_flash,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_FLIGHT, S_CUT, S_MISS, S_GAME_OVER
  } state_t;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] GRACE      = 8'(GRACE_FRAMES);
  localparam logic [7:0] HOLD_LAST  = 8'(CUT_HOLD - 1);
  localparam logic [9:0] YMAX       = 10'(Y_MAX);
  localparam logic [7:0] TIMEOUT    = 8'(FLIGHT_TIMEOUT);

`ifdef FRUIT_CTRL_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t     r_state;
  logic [7:0] r_flight_cnt;
  logic [7:0] r_hold_cnt;

  // 11-bit two's-complement differences so 0 vs 1023 never wraps into a hit
  logic [10:0] w_dx, w_dy, w_adx, w_ady;
  logic        w_hit, w_offscreen, w_timeout, w_miss;

  assign w_dx  = {1'b0, bladeX} - {1'b0, fruitX};
  assign w_dy  = {1'b0, bladeY} - {1'b0, fruitY};
  assign w_adx = w_dx[10] ? (~w_dx + 11'd1) : w_dx;
  assign w_ady = w_dy[10] ? (~w_dy + 11'd1) : w_dy;

  assign w_hit       = blade_valid && (w_adx <= {1'b0, fruitS}) && (w_ady <= {1'b0, fruitS});
  assign w_offscreen = fruitY > YMAX;
  assign w_timeout   = TIMEOUT_EN && (r_flight_cnt == TIMEOUT);
  assign w_miss      = ((r_flight_cnt >= GRACE) && w_offscreen) || w_timeout;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state              <= S_IDLE;
      r_flight_cnt         <= 8'd0;
      r_hold_cnt           <= 8'd0;
      new_fruit            <= 1'b0;
      move_fruit           <= 1'b0;
      number_of_fruits_cut <= 8'd0;
      lives                <= LIVES_INIT;
      cut_flash            <= 1'b0;
      game_over            <= 1'b0;
    end else begin
      new_fruit <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state              <= S_LAUNCH;
            new_fruit            <= 1'b1;
            r_flight_cnt         <= 8'd0;
            number_of_fruits_cut <= 8'd0;
            lives                <= LIVES_INIT;
          end
        end
        S_LAUNCH: begin
          r_state      <= S_FLIGHT;
          move_fruit   <= 1'b1;
          r_flight_cnt <= 8'd0;
        end
        S_FLIGHT: begin
          // a hit outranks a simultaneous miss, grace or not
          if (w_hit) begin
            r_state    <= S_CUT;
            move_fruit <= 1'b0;
            cut_flash  <= 1'b1;
            r_hold_cnt <= 8'd0;
            if (number_of_fruits_cut != 8'hFF)
              number_of_fruits_cut <= number_of_fruits_cut + 8'd1;
          end else if (w_miss) begin
            r_state    <= S_MISS;
            move_fruit <= 1'b0;
            lives      <= lives - 3'd1;
          end else if (r_flight_cnt != 8'hFF) begin
            r_flight_cnt <= r_flight_cnt + 8'd1;
          end
        end
        S_CUT: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state      <= S_LAUNCH;
            cut_flash    <= 1'b0;
            new_fruit    <= 1'b1;
            r_flight_cnt <= 8'd0;
            r_hold_cnt   <= 8'd0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        S_MISS: begin
          if (lives == 3'd0) begin
            r_state   <= S_GAME_OVER;
            game_over <= 1'b1;
          end else begin
            r_state      <= S_LAUNCH;
            new_fruit    <= 1'b1;
            r_flight_cnt <= 8'd0;
          end
        end
        S_GAME_OVER: begin
          if (start) begin
            r_state              <= S_LAUNCH;
            game_over            <= 1'b0;
            new_fruit            <= 1'b1;
            r_flight_cnt         <= 8'd0;
            number_of_fruits_cut <= 8'd0;
            lives                <= LIVES_INIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
